mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative signed multiply/divide unit for the multicycle processor datapath. It executes `mult` and `div` at the request of `control_unit` and writes the 64-bit result into the HI/LO pair. It returns a one-cycle completion pulse on `mult_end` and flags division by zero. It is the responder side of the `mult_control` / `DivOp` / `mult_end` handshake that `control_unit` initiates.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. The iteration count equals `WIDTH`.

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `mult_control`  in  1  start a signed multiply; level, sampled only in IDLE
- `DivOp`  in  1  start a signed divide; level, sampled only in IDLE
- `A`  in  WIDTH  multiplicand / dividend (A register output)
- `B`  in  WIDTH  multiplier / divisor (B register output)
- `hi`  out  WIDTH  upper product word / remainder
- `lo`  out  WIDTH  lower product word / quotient
- `mult_end`  out  1  one-cycle completion pulse to `control_unit`
- `div_zero`  out  1  one-cycle pulse, coincident with `mult_end`, when the divisor was 0
- `busy`  out  1  high from the cycle after the start is sampled until `mult_end` deasserts

## Operation
- States: IDLE, MULT, DIV, DONE.
- **IDLE**
  - If `mult_control` is sampled high, latch A and B and go to MULT. This has priority over `DivOp` when both are high.
  - Else if `DivOp` is high and B ≠ 0, latch operands and go to DIV.
  - Else if `DivOp` is high and B = 0, go to DONE with `div_zero` set. HI and LO are not modified.
  - The iteration counter is cleared on entry to MULT or DIV.
- **MULT**
  - Radix-2 Booth algorithm on a 2·WIDTH+1 accumulator (product, multiplier, Q-1 bit).
  - Each cycle: add or subtract the multiplicand from the upper half according to {Q0, Q-1}, then arithmetic shift right by 1.
  - After `WIDTH` iterations, load the upper half into `hi` and the lower half into `lo`, then go to DONE.
- **DIV**
  - Restoring division on operand magnitudes.
  - Each cycle: shift the remainder/quotient pair left, trial-subtract the divisor, and restore if the result is negative.
  - After `WIDTH` iterations, apply signs:
    - quotient is negated if the operand signs differ, so it truncates toward zero;
    - remainder takes the sign of the dividend.
  - Load the remainder into `hi` and the quotient into `lo`, then go to DONE.
- **DONE**: `mult_end` = 1 and `busy` = 1 for exactly one cycle, then return to IDLE.
- Start inputs seen outside IDLE are ignored. No queuing.
- Arithmetic wraps modulo 2^WIDTH with no overflow flag. -2^(WIDTH-1) / -1 gives LO = 0x80000000 and HI = 0.
- `hi` and `lo` change only at the edge that enters DONE. They hold their value otherwise, including across a divide-by-zero.

## Timing
- Reset values, applied immediately while `reset` = 0 (asynchronous):
  - state = IDLE, counter = 0
  - `hi` = 0, `lo` = 0
  - `mult_end` = 0, `div_zero` = 0, `busy` = 0
- Reset asserted mid-operation aborts the operation. No completion pulse is produced.
- Start sampled at edge E0. Iterations run on edges E1..E32. The result is registered and `mult_end` rises at edge E32. `mult_end` falls at E33, which is also when the block returns to IDLE.
- Latency: 32 edges (`WIDTH`) from start sample to `mult_end` high. The next start can be sampled at E34 at the earliest.
- Divide by zero: `mult_end` and `div_zero` rise at E1 and fall at E2.
- `busy` is registered. It is high from E1 through the DONE cycle.
- `control_unit` must hold its operands until the start is sampled. The unit does not depend on A and B after E0.

## Test plan
- After reset release, `mult_control` = 1 with A = 3, B = 0xFFFFFFFC (-4):
  - `mult_end` pulses exactly 32 edges after the sample;
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFF4.
- Multiply A = B = 0x80000000 → HI = 0x40000000, LO = 0. Multiply A = 0xFFFFFFFF, B = 0xFFFFFFFF → HI = 0, LO = 1.
- `DivOp` with A = 0xFFFFFFF9 (-7), B = 2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). Also A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- `DivOp` with B = 0 after a prior result HI = 5, LO = 7 → `div_zero` and `mult_end` high for one cycle at E1; HI = 5 and LO = 7 unchanged.
- `mult_control` and `DivOp` asserted together with A = 6, B = 3 → multiply runs: HI = 0, LO = 18. Re-asserting `DivOp` mid-operation is ignored: exactly one `mult_end` pulse.
- Assert `reset` low at iteration 10 of a multiply → all outputs 0 at once. No `mult_end` afterwards. A fresh multiply 2 × 5 gives LO = 10.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between control_unit (master) and the
// iterative multiply/divide unit (slave).
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             mult_control;
   logic             DivOp;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             mult_end;
   logic             div_zero;
   logic             busy;

   modport master (
      output mult_control, DivOp, A, B,
      input  hi, lo, mult_end, div_zero, busy
   );

   modport slave (
      input  mult_control, DivOp, A, B,
      output hi, lo, mult_end, div_zero, busy
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit.
// One iteration per clock; the result lands in HI/LO with a one-cycle mult_end pulse.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   mult_div_unit_if.slave    bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [CW-1:0]      cnt_r;
   logic               last_s;

   // Booth accumulator carries one guard bit so that subtracting -2^(WIDTH-1) cannot overflow
   logic [2*WIDTH+1:0] acc_r;
   logic [2*WIDTH+1:0] booth_nx_s;
   logic [WIDTH:0]     upper_s;
   logic [WIDTH:0]     mcand_ext_s;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH-1:0]   mcand_r;

   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   quo_r;
   logic [WIDTH-1:0]   divisor_r;
   logic               neg_q_r;
   logic               neg_r_r;
   logic               dz_r;
   logic [WIDTH:0]     rem_sh_s;
   logic [WIDTH:0]     trial_s;
   logic [WIDTH-1:0]   rem_nx_s;
   logic [WIDTH-1:0]   quo_nx_s;

   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               mult_end_r;
   logic               div_zero_r;
   logic               busy_r;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
      neg_if = n ? (~v + WIDTH'(1)) : v;
   endfunction

   assign last_s = (cnt_r == CW'(WIDTH - 1));

   // Booth add/subtract followed by arithmetic shift right, and one restoring-division step
   always_comb begin
      upper_s     = acc_r[2*WIDTH+1:WIDTH+1];
      mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
      case (acc_r[1:0])
         2'b01:   sum_s = upper_s + mcand_ext_s;
         2'b10:   sum_s = upper_s - mcand_ext_s;
         default: sum_s = upper_s;
      endcase
      booth_nx_s = {sum_s[WIDTH], sum_s, acc_r[WIDTH:1]};

      rem_sh_s = {rem_r, quo_r[WIDTH-1]};
      trial_s  = rem_sh_s - {1'b0, divisor_r};
      if (trial_s[WIDTH]) begin
         rem_nx_s = rem_sh_s[WIDTH-1:0];
      end else begin
         rem_nx_s = trial_s[WIDTH-1:0];
      end
      quo_nx_s = {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
   end

   // Next-state logic; a zero divisor spends one DIV cycle so its pulse appears at E1
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.mult_control) begin
               state_nx_s = ST_MULT;
            end else if (bus.DivOp) begin
               state_nx_s = ST_DIV;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_MULT: begin
            if (last_s) state_nx_s = ST_DONE;
            else        state_nx_s = ST_MULT;
         end
         ST_DIV: begin
            if (dz_r || last_s) state_nx_s = ST_DONE;
            else                state_nx_s = ST_DIV;
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= ST_IDLE;
      else        state_r <= state_nx_s;
   end

   // Operand capture, iteration datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r      <= '0;
         acc_r      <= '0;
         mcand_r    <= '0;
         rem_r      <= '0;
         quo_r      <= '0;
         divisor_r  <= '0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         dz_r       <= 1'b0;
         hi_r       <= '0;
         lo_r       <= '0;
         mult_end_r <= 1'b0;
         div_zero_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               mult_end_r <= 1'b0;
               div_zero_r <= 1'b0;
               cnt_r      <= '0;
               if (bus.mult_control) begin
                  acc_r   <= {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
                  mcand_r <= bus.A;
                  busy_r  <= 1'b1;
               end else if (bus.DivOp) begin
                  rem_r     <= '0;
                  quo_r     <= neg_if(bus.A, bus.A[WIDTH-1]);
                  divisor_r <= neg_if(bus.B, bus.B[WIDTH-1]);
                  neg_q_r   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                  neg_r_r   <= bus.A[WIDTH-1];
                  dz_r      <= (bus.B == '0);
                  busy_r    <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_MULT: begin
               acc_r <= booth_nx_s;
               cnt_r <= cnt_r + CW'(1);
               if (last_s) begin
                  hi_r       <= booth_nx_s[2*WIDTH:WIDTH+1];
                  lo_r       <= booth_nx_s[WIDTH:1];
                  mult_end_r <= 1'b1;
               end
            end
            ST_DIV: begin
               if (dz_r) begin
                  mult_end_r <= 1'b1;
                  div_zero_r <= 1'b1;
               end else begin
                  rem_r <= rem_nx_s;
                  quo_r <= quo_nx_s;
                  cnt_r <= cnt_r + CW'(1);
                  if (last_s) begin
                     hi_r       <= neg_if(rem_nx_s, neg_r_r);
                     lo_r       <= neg_if(quo_nx_s, neg_q_r);
                     mult_end_r <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               mult_end_r <= 1'b0;
               div_zero_r <= 1'b0;
               busy_r     <= 1'b0;
            end
            default: begin
               mult_end_r <= 1'b0;
               div_zero_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
   assign bus.mult_end = mult_end_r;
   assign bus.div_zero = div_zero_r;
   assign bus.busy     = busy_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
   logic clk;
   logic reset;
   int   vectors;
   int   errs;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic mul, input logic div,
                         input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
      int  n;
      bit  done;
      @(negedge clk);
      bus.A = a;
      bus.B = b;
      bus.mult_control = mul;
      bus.DivOp = div;
      @(posedge clk);
      #1;
      bus.mult_control = 1'b0;
      bus.DivOp = 1'b0;
      check_vec({tag, " busy"}, 64'(bus.busy), 64'd1);
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.mult_end) done = 1'b1;
      end
      check_vec({tag, " latency"}, 64'(n), 64'(exp_lat));
      check_vec({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
      check_vec({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
      check_vec({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
      @(posedge clk);
      #1;
      check_vec({tag, " end_fall"}, {61'd0, bus.mult_end, bus.busy, bus.div_zero}, 64'd0);
   endtask

   initial begin
      int pulses;
      logic [31:0] cap_hi;
      logic [31:0] cap_lo;
      vectors = 0;
      errs = 0;
      reset = 1'b0;
      bus.mult_control = 1'b0;
      bus.DivOp = 1'b0;
      bus.A = 32'd0;
      bus.B = 32'd0;
      repeat (3) @(negedge clk);
      check_vec("reset hi", 64'(bus.hi), 64'd0);
      check_vec("reset lo", 64'(bus.lo), 64'd0);
      check_vec("reset flags", {61'd0, bus.mult_end, bus.busy, bus.div_zero}, 64'd0);
      reset = 1'b1;

      run_op("mul 3*-4", 1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC, 32, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);
      run_op("mul min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000, 32'h0, 1'b0);
      run_op("mul -1*-1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0, 32'h1, 1'b0);
      run_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0, 32'h8000_0000, 1'b0);
      run_op("div 100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32, 32'd2, 32'hFFFF_FFF2, 1'b0);
      run_op("div 54/7", 1'b0, 1'b1, 32'd54, 32'd7, 32, 32'd5, 32'd7, 1'b0);
      run_op("div by 0", 1'b0, 1'b1, 32'd99, 32'd0, 1, 32'd5, 32'd7, 1'b1);

      // Both starts together: multiply wins; a DivOp re-assert mid-run must be ignored
      @(negedge clk);
      bus.A = 32'd6;
      bus.B = 32'd3;
      bus.mult_control = 1'b1;
      bus.DivOp = 1'b1;
      @(posedge clk);
      #1;
      bus.mult_control = 1'b0;
      bus.DivOp = 1'b0;
      pulses = 0;
      cap_hi = 32'hDEAD_BEEF;
      cap_lo = 32'hDEAD_BEEF;
      for (int i = 1; i <= 45; i++) begin
         if (i == 5) bus.DivOp = 1'b1;
         if (i == 9) bus.DivOp = 1'b0;
         @(posedge clk);
         #1;
         if (bus.mult_end) begin
            pulses++;
            cap_hi = bus.hi;
            cap_lo = bus.lo;
         end
      end
      check_vec("both pulses", 64'(pulses), 64'd1);
      check_vec("both hi", 64'(cap_hi), 64'd0);
      check_vec("both lo", 64'(cap_lo), 64'd18);

      // Reset at iteration 10 aborts the multiply with no completion pulse
      @(negedge clk);
      bus.A = 32'h1234;
      bus.B = 32'd7;
      bus.mult_control = 1'b1;
      @(posedge clk);
      #1;
      bus.mult_control = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_vec("abort hi", 64'(bus.hi), 64'd0);
      check_vec("abort lo", 64'(bus.lo), 64'd0);
      check_vec("abort flags", {61'd0, bus.mult_end, bus.busy, bus.div_zero}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.mult_end) pulses++;
      end
      check_vec("abort no_end", 64'(pulses), 64'd0);
      run_op("mul 2*5", 1'b1, 1'b0, 32'd2, 32'd5, 32, 32'd0, 32'd10, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
